// File: rtl/key_pkg.sv
// Shared definitions for the one-hot key capture front end: key bus width
// and the capture FSM state encoding.
package key_pkg;

  localparam int KEY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESENT  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

endpackage : key_pkg

// File: rtl/onehot_key_capture_if.sv
// Valid/ready bus carrying the accepted one-hot key code to the encoder.
// The capture block is the master; the encoder is the slave.
interface onehot_key_capture_if;
  import key_pkg::*;

  logic [KEY_W-1:0] y;
  logic             valid;
  logic             ready;

  modport master (
    output y,
    output valid,
    input  ready
  );

  modport slave (
    input  y,
    input  valid,
    output ready
  );

endinterface : onehot_key_capture_if

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by the
// asynchronous active-low reset.
module sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] ff0_q;
  logic [WIDTH-1:0] ff1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff0_q <= '0;
      ff1_q <= '0;
    end else begin
      ff0_q <= d_i;
      ff1_q <= ff0_q;
    end
  end

  assign q_o = ff1_q;

endmodule : sync2

// File: rtl/onehot_key_capture.sv
// Synchronizes and debounces eight push-button lines and hands exactly one
// accepted one-hot key at a time to the encoder over a valid/ready bus.
module onehot_key_capture
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_W-1:0]      btn_raw,
  onehot_key_capture_if.master  key_if,
  output logic                  multi_err,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0] btn_s;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] snap_q,  snap_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [KEY_W-1:0] y_q,     y_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic             snap_onehot;

  sync2 #(
    .WIDTH (KEY_W)
  ) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_raw),
    .q_o   (btn_s)
  );

  assign snap_onehot = (snap_q != '0) && ((snap_q & (snap_q - KEY_W'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (btn_s != '0) begin
          snap_d  = btn_s;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end

      // Any change of the pattern restarts the whole stability window.
      ST_DEBOUNCE: begin
        if (btn_s == '0) begin
          state_d = ST_IDLE;
        end else if (btn_s != snap_q) begin
          snap_d = btn_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (snap_onehot) begin
            y_d     = snap_q;
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PRESENT: begin
        if (key_if.ready) begin
          y_d     = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      // Keys must be fully released and stay released before re-arming.
      ST_RELEASE: begin
        if (btn_s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign key_if.y     = y_q;
  assign key_if.valid = valid_q;
  assign multi_err    = err_q;
  assign busy         = (state_q != ST_IDLE);

  a_y_zero_when_idle: assert property (
    @(posedge clk) disable iff (!rst_n) !valid_q |-> (y_q == '0));

  a_y_onehot_or_zero: assert property (
    @(posedge clk) disable iff (!rst_n) ((y_q & (y_q - KEY_W'(1))) == '0));

  a_err_single_pulse: assert property (
    @(posedge clk) disable iff (!rst_n) err_q |=> !err_q);

endmodule : onehot_key_capture

// File: tb/tb_onehot_key_capture.sv
// Bench for onehot_key_capture: directed vector table, reset-in-PRESENT
// sequence and random button traffic compared against a run-length model.
module tb_onehot_key_capture;

  localparam int D = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] btn_raw = 8'h00;
  logic       multi_err;
  logic       busy;

  onehot_key_capture_if key_if ();

  onehot_key_capture #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .key_if    (key_if),
    .multi_err (multi_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference: two-sample delay line, run length of the synchronized stream,
  // and a count of zero samples while waiting for release.
  logic [7:0] m_q0 = 0, m_q1 = 0, m_prev = 0, m_y = 0;
  int         m_run = 0, m_zero = 0, m_phase = 0;  // 0 wait, 1 hold, 2 release
  bit         m_valid = 0, m_err = 0;
  logic [7:0] m_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q0 = 0; m_q1 = 0; m_prev = 0; m_y = 0;
      m_run = 0; m_zero = 0; m_phase = 0; m_valid = 0; m_err = 0;
    end else begin
      m_s   = m_q1;
      m_q1  = m_q0;
      m_q0  = btn_raw;
      m_run = (m_s == m_prev) ? m_run + 1 : 1;
      m_err = 0;
      case (m_phase)
        0: if (m_s != 0 && m_run == D + 1) begin
             if ($countones(m_s) == 1) begin
               m_y = m_s; m_valid = 1; m_phase = 1;
             end else begin
               m_err = 1; m_phase = 2; m_zero = 0;
             end
           end
        1: if (key_if.ready) begin
             m_y = 0; m_valid = 0; m_phase = 2; m_zero = 0;
           end
        default: begin
          m_zero = (m_s == 0) ? m_zero + 1 : 0;
          if (m_zero == D) m_phase = 0;
        end
      endcase
      m_prev = m_s;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit m_busy;
      m_busy = (m_phase != 0) || (m_prev != 0);
      n_checks++;
      if (key_if.y !== m_y || key_if.valid !== m_valid ||
          multi_err !== m_err || busy !== m_busy) begin
        n_fail++;
        $display("FAIL model t=%0t: got y=%h v=%b e=%b b=%b, want y=%h v=%b e=%b b=%b",
                 $time, key_if.y, key_if.valid, multi_err, busy,
                 m_y, m_valid, m_err, m_busy);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] ey, input bit ev,
                       input bit ee, input bit eb);
    n_checks++;
    if (key_if.y !== ey || key_if.valid !== ev || multi_err !== ee || busy !== eb) begin
      n_fail++;
      $display("FAIL %s: got y=%h v=%b e=%b b=%b, want y=%h v=%b e=%b b=%b",
               name, key_if.y, key_if.valid, multi_err, busy, ey, ev, ee, eb);
    end
  endtask

  typedef struct {
    logic [7:0] btn;
    bit         rdy;
    int         n;
    logic [7:0] ey;
    bit         ev;
    bit         ee;
    bit         eb;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [7:0] btn, bit rdy, int n, logic [7:0] ey,
                              bit ev, bit ee, bit eb);
    vec_t v;
    v = '{btn, rdy, n, ey, ev, ee, eb};
    tbl.push_back(v);
  endfunction

  initial begin
    key_if.ready = 1'b0;

    // clean press of bit 5, ready high
    add(8'h20, 1, 5,  8'h00, 0, 0, 1);
    add(8'h20, 1, 1,  8'h00, 0, 0, 1);
    add(8'h20, 1, 1,  8'h20, 1, 0, 1);
    add(8'h20, 1, 1,  8'h00, 0, 0, 1);
    add(8'h20, 1, 12, 8'h00, 0, 0, 1);
    add(8'h00, 1, 5,  8'h00, 0, 0, 1);
    add(8'h00, 1, 1,  8'h00, 0, 0, 0);
    // bit 2 with ready held low
    add(8'h04, 0, 6,  8'h00, 0, 0, 1);
    add(8'h04, 0, 1,  8'h04, 1, 0, 1);
    add(8'h04, 0, 10, 8'h04, 1, 0, 1);
    add(8'h04, 1, 1,  8'h00, 0, 0, 1);
    add(8'h00, 0, 5,  8'h00, 0, 0, 1);
    add(8'h00, 0, 1,  8'h00, 0, 0, 0);
    // two keys together
    add(8'h42, 1, 6,  8'h00, 0, 0, 1);
    add(8'h42, 1, 1,  8'h00, 0, 1, 1);
    add(8'h42, 1, 1,  8'h00, 0, 0, 1);
    add(8'h42, 1, 5,  8'h00, 0, 0, 1);
    add(8'h00, 1, 5,  8'h00, 0, 0, 1);
    add(8'h00, 1, 1,  8'h00, 0, 0, 0);
    // bit 3 bouncing
    add(8'h08, 1, 2,  8'h00, 0, 0, 0);
    add(8'h00, 1, 1,  8'h00, 0, 0, 1);
    add(8'h08, 1, 6,  8'h00, 0, 0, 1);
    add(8'h08, 1, 1,  8'h08, 1, 0, 1);
    add(8'h08, 1, 1,  8'h00, 0, 0, 1);
    add(8'h00, 1, 5,  8'h00, 0, 0, 1);
    add(8'h00, 1, 1,  8'h00, 0, 0, 0);
    // key held past the handshake, then a fresh press of bit 0
    add(8'h10, 1, 6,  8'h00, 0, 0, 1);
    add(8'h10, 1, 1,  8'h10, 1, 0, 1);
    add(8'h10, 1, 50, 8'h00, 0, 0, 1);
    add(8'h00, 1, 5,  8'h00, 0, 0, 1);
    add(8'h00, 1, 1,  8'h00, 0, 0, 0);
    add(8'h01, 1, 6,  8'h00, 0, 0, 1);
    add(8'h01, 1, 1,  8'h01, 1, 0, 1);
    add(8'h00, 1, 1,  8'h00, 0, 0, 1);
    add(8'h00, 1, 4,  8'h00, 0, 0, 1);
    add(8'h00, 1, 1,  8'h00, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 check("reset", 8'h00, 0, 0, 0);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      btn_raw      = tbl[i].btn;
      key_if.ready = tbl[i].rdy;
      repeat (tbl[i].n) @(posedge clk);
      #1 check($sformatf("vec%0d", i), tbl[i].ey, tbl[i].ev, tbl[i].ee, tbl[i].eb);
    end

    // reset while presenting 8'h80, key still held afterwards
    @(negedge clk);
    btn_raw      = 8'h80;
    key_if.ready = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("present_80", 8'h80, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n        = 1'b1;
    key_if.ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("held_rel_wait", 8'h00, 0, 0, 1);
    @(posedge clk);
    #1 check("held_rel_accept", 8'h80, 1, 0, 1);
    @(negedge clk);
    btn_raw = 8'h00;
    repeat (10) @(posedge clk);
    #1 check("held_rel_idle", 8'h00, 0, 0, 0);

    // random traffic against the model
    for (int seg = 0; seg < 400; seg++) begin
      int         kind;
      int         hold;
      logic [7:0] pat;
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 12);
      case (kind)
        0:       pat = 8'h00;
        1:       pat = 8'h01 << $urandom_range(0, 7);
        2:       pat = 8'($urandom);
        default: pat = btn_raw;
      endcase
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        btn_raw      = pat;
        key_if.ready = ($urandom_range(0, 9) < 7);
        @(posedge clk);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_onehot_key_capture
